// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: three requesters share one write port; clears the bank after reset.
// Define RR_ARB_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [2:0]      req_valid,
  output logic [2:0]      req_ready,
  input  logic [3*AW-1:0] req_reg,
  input  logic [3*DW-1:0] req_data,
  output logic            regWen,
  output logic [AW-1:0]   writeReg,
  output logic [DW-1:0]   writeData,
  output logic            init_done,
  output logic [15:0]     stall_cnt
);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] sweep_idx;
  logic [2:0]    grant;
  logic          accept;
  logic          stall;
  logic [AW-1:0] sel_reg;
  logic [DW-1:0] sel_data;

  function automatic logic [2:0] first_set(input logic [2:0] v);
    if (v[0]) return 3'b001;
    else if (v[1]) return 3'b010;
    else if (v[2]) return 3'b100;
    return 3'b000;
  endfunction

`ifdef RR_ARB_EN
  logic [1:0] rr_ptr;
  logic [2:0] rot_valid, rot_grant;

  // Rotate so the pointed-to requester sits at bit 0, pick, then rotate back.
  always_comb begin
    case (rr_ptr)
      2'd1:    rot_valid = {req_valid[0], req_valid[2], req_valid[1]};
      2'd2:    rot_valid = {req_valid[1], req_valid[0], req_valid[2]};
      default: rot_valid = req_valid;
    endcase
    rot_grant = first_set(rot_valid);
    case (rr_ptr)
      2'd1:    grant = {rot_grant[1], rot_grant[0], rot_grant[2]};
      2'd2:    grant = {rot_grant[0], rot_grant[2], rot_grant[1]};
      default: grant = rot_grant;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) rr_ptr <= 2'd0;
    else if (accept) rr_ptr <= grant[0] ? 2'd1 : (grant[1] ? 2'd2 : 2'd0);
  end
`else
  assign grant = first_set(req_valid);
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) state <= INIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 3'b000;
    case (state)
      INIT:    if (sweep_idx == {AW{1'b1}}) state_nxt = RUN;
      RUN:     req_ready = Rst ? grant : 3'b000;
      default: state_nxt = INIT;
    endcase
  end

  assign accept = |(req_valid & req_ready);
  assign stall  = (state == RUN) && Rst && (|(req_valid & ~req_ready));

  always_comb begin
    sel_reg  = req_reg[0 +: AW];
    sel_data = req_data[0 +: DW];
    if (grant[1]) begin
      sel_reg  = req_reg[AW +: AW];
      sel_data = req_data[DW +: DW];
    end
    if (grant[2]) begin
      sel_reg  = req_reg[2*AW +: AW];
      sel_data = req_data[2*DW +: DW];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sweep_idx <= '0;
      regWen    <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      init_done <= 1'b0;
      stall_cnt <= '0;
    end else begin
      // init_done trails the state change so it rises after the last sweep write is visible
      init_done <= init_done | (state == RUN);
      if (state == INIT) begin
        regWen    <= 1'b1;
        writeReg  <= sweep_idx;
        writeData <= '0;
        sweep_idx <= sweep_idx + 1'b1;
      end else begin
        regWen <= accept && (sel_reg != '0);
        if (accept) begin
          writeReg  <= sel_reg;
          writeData <= sel_data;
        end
      end
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a cycle-level behavioural model of the write port.
module tb_regfile_wb_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [3*AW-1:0] req_reg;
  logic [3*DW-1:0] req_data;
  logic            regWen;
  logic [AW-1:0]   writeReg;
  logic [DW-1:0]   writeData;
  logic            init_done;
  logic [15:0]     stall_cnt;

  always #5 Clk = ~Clk;

  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data),
    .regWen(regWen), .writeReg(writeReg), .writeData(writeData),
    .init_done(init_done), .stall_cnt(stall_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  bit          m_run   = 0;
  bit          m_init  = 0;
  int          m_sweep = 0;
  int          m_ptr   = 0;
  int          m_stall = 0;
  bit          m_wen   = 0;
  int          m_reg   = 0;
  logic [31:0] m_data  = '0;
  int          m_last_g = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
  endtask

  // first valid requester starting from ptr, wrapping mod 3
  function automatic int pick(input logic [2:0] v, input int ptr);
    int r;
    for (int k = 0; k < 3; k++) begin
      r = (ptr + k) % 3;
      if (v[r]) return r;
    end
    return -1;
  endfunction

  task automatic step();
    int g;
    logic [2:0] exp_rdy;
    bit was_run;
    @(negedge Clk);
    g = (Rst && m_run) ? pick(req_valid, m_ptr) : -1;
    exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge Clk);
    was_run = m_run;
    if (!Rst) begin
      m_run = 0; m_init = 0; m_sweep = 0; m_ptr = 0; m_stall = 0;
      m_wen = 0; m_reg = 0; m_data = '0;
    end else if (!m_run) begin
      m_wen = 1; m_reg = m_sweep; m_data = '0;
      if (m_sweep == NREG - 1) m_run = 1;
      m_sweep++;
    end else begin
      m_init = 1;
      if (g >= 0) begin
        m_reg  = int'(req_reg[g*AW +: AW]);
        m_data = req_data[g*DW +: DW];
        m_wen  = (m_reg != 0);
`ifdef RR_ARB_EN
        m_ptr = (g + 1) % 3;
`endif
      end else begin
        m_wen = 0;
      end
      if ((req_valid & ~exp_rdy) != 3'b000 && m_stall < 65535) m_stall++;
    end
    if (Rst && was_run) m_init = 1;
    m_last_g = g;
    #1;
    check_eq("regWen", 32'(regWen), 32'(m_wen));
    check_eq("writeReg", 32'(writeReg), 32'(m_reg));
    check_eq("writeData", writeData, m_data);
    check_eq("init_done", 32'(init_done), 32'(m_init));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  initial begin
    Rst = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
    repeat (2) step();

    // clearing sweep
    Rst = 1'b1;
    step();
    check_eq("sweep_first_reg", 32'(writeReg), 32'd0);
    repeat (NREG) step();
    check_eq("init_after_sweep", 32'(init_done), 32'd1);

    // all three valid, held three cycles
    req_valid = 3'b111;
    req_reg   = {5'd7, 5'd5, 5'd3};
    req_data  = {32'hC, 32'hB, 32'hA};
    repeat (3) step();
    req_valid = 3'b000;
    step();

    // write to register 0 is consumed without a write
    req_reg = '0;
    req_data[DW +: DW] = 32'hDEADBEEF;
    req_valid = 3'b010;
    step();
    req_valid = 3'b000;
    step();
    check_eq("reg0_no_write", 32'(regWen), 32'd0);

    // lone request from requester 2
    req_reg[2*AW +: AW] = 5'd31;
    req_data[2*DW +: DW] = 32'h1234;
    req_valid = 3'b100;
    step();
    req_valid = 3'b000;
    check_eq("r2_wen", 32'(regWen), 32'd1);
    check_eq("r2_data", writeData, 32'h1234);
    step();
    check_eq("r2_drop", 32'(regWen), 32'd0);

    // reset pulse mid-sweep at sweep_idx 17
    Rst = 1'b0; step();
    Rst = 1'b1;
    repeat (17) step();
    Rst = 1'b0; step();
    check_eq("abort_wen", 32'(regWen), 32'd0);
    Rst = 1'b1; step();
    check_eq("restart_reg", 32'(writeReg), 32'd0);
    repeat (NREG - 1) step();
    check_eq("init_low_at_last", 32'(init_done), 32'd0);
    step();
    check_eq("init_high_after", 32'(init_done), 32'd1);

    // random traffic; losing requests stay stable until granted
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || m_last_g == i) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_reg[i*AW +: AW] = 5'($urandom_range(0, NREG - 1));
          req_data[i*DW +: DW] = $urandom;
        end
      end
      step();
    end

    // drive stall counter into saturation
    req_valid = 3'b111;
    repeat (65540) step();
    check_eq("stall_sat", 32'(stall_cnt), 32'hFFFF);
    repeat (3) step();
    check_eq("stall_hold", 32'(stall_cnt), 32'hFFFF);
    req_valid = 3'b000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
